alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_regfile.sv | 30 +++
 rtl/alu_operand_stage.sv | 100 ++++++++++
 tb/tb_alu_operand_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, datapath widths and issue FSM states.
// Used by alu_regfile and alu_operand_stage.
package alu_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_e;

  // One-hot select of a register address, used for scoreboard set/clear.
  function automatic logic [NUM_REGS-1:0] addr_mask(input logic [REG_AW-1:0] a);
    addr_mask    = '0;
    addr_mask[a] = 1'b1;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous write
// port, synchronous clear. Register 0 always reads zero and is never written.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand-fetch/issue stage with pending-write scoreboard and stall counter.
// Define ALU_OPERAND_BYPASS_EN to forward same-cycle write-back data to rs/rt.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_sel,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [15:0]       stall_cnt
);

  logic [DATA_W-1:0]   rd_a, rd_b, src_a, src_b;
  logic [NUM_REGS-1:0] pending, pend_set, pend_clr;
  logic                wb_we, fwd_a, fwd_b, hazard, slot_free, accept;
  issue_state_e        state, state_nxt;

  assign wb_we = wb_en & ~rst;

  alu_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (in_rs),
    .rdata_a (rd_a),
    .raddr_b (in_rt),
    .rdata_b (rd_b)
  );

`ifdef ALU_OPERAND_BYPASS_EN
  assign fwd_a = wb_en && (wb_addr == in_rs) && (in_rs != '0);
  assign fwd_b = wb_en && (wb_addr == in_rt) && (in_rt != '0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign src_a = fwd_a ? wb_data : rd_a;
  assign src_b = fwd_b ? wb_data : rd_b;

  // Sources only escape the hazard when forwarding supplies the new value;
  // the destination only needs the outstanding write to be retiring now.
  assign pend_clr  = wb_en ? addr_mask(wb_addr) : '0;
  assign hazard    = (pending[in_rs] & ~fwd_a) | (pending[in_rt] & ~fwd_b) |
                     (pending[in_rd] & ~pend_clr[in_rd]);
  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = slot_free & ~hazard & ~rst;
  assign accept    = in_valid & in_ready;
  assign pend_set  = accept ? addr_mask(in_rd) : '0;
  assign out_valid = (state == ST_FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      pending   <= '0;
      stall_cnt <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_sel   <= '0;
      out_rd    <= '0;
    end else begin
      state   <= state_nxt;
      // Set wins over clear so a re-issued destination stays pending.
      pending <= ((pending & ~pend_clr) | pend_set) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
      if (in_valid && slot_free && hazard && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (accept) begin
        out_a   <= src_a;
        out_b   <= src_b;
        out_sel <= in_sel;
        out_rd  <= in_rd;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus random
// traffic against a cycle-level behavioural model of the stage.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_sel;
  logic [4:0]  out_rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [15:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_sel;
  logic [4:0]  m_rd;
  int          m_stall;

  alu_operand_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sel   (out_sel),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = '0;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_a = '0; m_b = '0; m_sel = '0; m_rd = '0;
    m_stall = 0;
  endtask

  // A source is blocked while its register awaits write-back, unless forwarding
  // hands over this cycle's write-back value.
  function automatic bit m_src_blocked(input logic [4:0] r);
    if (r == 0 || !m_pend[r]) return 1'b0;
`ifdef ALU_OPERAND_BYPASS_EN
    if (wb_en && wb_addr == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit m_hazard();
    bit dst_blocked;
    dst_blocked = (in_rd != 0) && m_pend[in_rd] && !(wb_en && wb_addr == in_rd);
    return m_src_blocked(in_rs) || m_src_blocked(in_rt) || dst_blocked;
  endfunction

  function automatic bit m_ready();
    return !rst && (!m_valid || out_ready) && !m_hazard();
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
`ifdef ALU_OPERAND_BYPASS_EN
    if (wb_en && wb_addr == r) return wb_data;
`endif
    return m_rf[r];
  endfunction

  task automatic model_edge();
    bit acc, free, hz;
    logic [31:0] a, b;
    if (rst) begin
      model_clear();
      return;
    end
    free = !m_valid || out_ready;
    hz   = m_hazard();
    acc  = in_valid && free && !hz;
    a    = m_read(in_rs);
    b    = m_read(in_rt);
    if (in_valid && free && hz && m_stall < 65535) m_stall++;
    if (acc) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_sel = in_sel; m_rd = in_rd;
    end else if (free) begin
      m_valid = 1'b0;
    end
    if (wb_en) m_pend[wb_addr] = 1'b0;
    if (acc && in_rd != 0) m_pend[in_rd] = 1'b1;
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
  endtask

  task automatic set_op(input logic [2:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    in_valid = 1'b1; in_sel = sel; in_rs = rs; in_rt = rt; in_rd = rd;
  endtask

  task automatic set_wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    set_op(3'd1, 5'd1, 5'd2, 5'd3);
    set_wb(5'd3, 32'h1234_5678);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL reset_in_ready got %b exp 0", in_ready); end
    tick();
    idle_inputs();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
    nvec++; if (out_a !== 32'd0 || out_b !== 32'd0) begin nerr++; $display("[TB] FAIL reset_operands got %h/%h exp 0/0", out_a, out_b); end
    nvec++; if (stall_cnt !== 16'd0) begin nerr++; $display("[TB] FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    // wb_en during reset must not have written r3
    set_op(3'd0, 5'd3, 5'd0, 5'd0);
    tick();
    in_valid = 1'b0;
    nvec++; if (out_a !== 32'd0) begin nerr++; $display("[TB] FAIL reset_wb_ignored got %h exp 0", out_a); end
  endtask

  task automatic test_basic_issue();
    do_reset();
    set_wb(5'd3, 32'd5); tick();
    set_wb(5'd4, 32'd7); tick();
    wb_en = 1'b0;
    set_op(3'd0, 5'd3, 5'd4, 5'd5);
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL basic_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("[TB] FAIL basic_out_valid got %b exp 1", out_valid); end
    nvec++; if (out_a !== 32'd5 || out_b !== 32'd7) begin nerr++; $display("[TB] FAIL basic_operands got %0d/%0d exp 5/7", out_a, out_b); end
    nvec++; if (out_sel !== 3'd0 || out_rd !== 5'd5) begin nerr++; $display("[TB] FAIL basic_sel_rd got %0d/%0d exp 0/5", out_sel, out_rd); end
    // pending[5] is visible as a hazard for a reader of r5
    set_op(3'd1, 5'd5, 5'd0, 5'd0);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL basic_pending5 in_ready got %b exp 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    set_op(3'd0, 5'd1, 5'd2, 5'd5);
    tick();
    set_op(3'd1, 5'd5, 5'd0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL stall_in_ready cycle %0d got %b exp 0", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    nvec++; if (stall_cnt !== 16'd3) begin nerr++; $display("[TB] FAIL stall_cnt got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_wb_forward();
    do_reset();
    set_op(3'd0, 5'd0, 5'd0, 5'd5);
    tick();
    in_valid = 1'b0;
    tick();
    set_op(3'd3, 5'd5, 5'd0, 5'd0);
    set_wb(5'd5, 32'd9);
    #1;
`ifdef ALU_OPERAND_BYPASS_EN
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL fwd_same_cycle in_ready got %b exp 1", in_ready); end
    tick();
`else
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL fwd_wb_cycle in_ready got %b exp 0", in_ready); end
    tick();
    wb_en = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL fwd_next_cycle in_ready got %b exp 1", in_ready); end
    tick();
`endif
    idle_inputs();
    nvec++; if (out_valid !== 1'b1 || out_a !== 32'd9) begin nerr++; $display("[TB] FAIL fwd_out_a got v=%b a=%0d exp v=1 a=9", out_valid, out_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_wb(5'd1, 32'd11); tick();
    wb_en = 1'b0;
    set_op(3'd2, 5'd1, 5'd0, 5'd3);
    tick();
    out_ready = 1'b0;
    set_op(3'd1, 5'd0, 5'd1, 5'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL hold_in_ready cycle %0d got %b exp 0", i, in_ready); end
      tick();
      nvec++; if (out_valid !== 1'b1 || out_a !== 32'd11 || out_sel !== 3'd2 || out_rd !== 5'd3) begin
        nerr++; $display("[TB] FAIL hold_stable cycle %0d got v=%b a=%0d sel=%0d rd=%0d exp v=1 a=11 sel=2 rd=3", i, out_valid, out_a, out_sel, out_rd);
      end
    end
    out_ready = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL b2b_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1 || out_b !== 32'd11 || out_sel !== 3'd1 || out_rd !== 5'd4) begin
      nerr++; $display("[TB] FAIL b2b_issue got v=%b b=%0d sel=%0d rd=%0d exp v=1 b=11 sel=1 rd=4", out_valid, out_b, out_sel, out_rd);
    end
  endtask

  task automatic test_r0();
    do_reset();
    set_wb(5'd0, 32'hDEADBEEF); tick();
    wb_en = 1'b0;
    set_op(3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    nvec++; if (out_a !== 32'd0) begin nerr++; $display("[TB] FAIL r0_read got %h exp 0", out_a); end
    set_wb(5'd0, 32'hDEADBEEF);
    tick();
    idle_inputs();
    nvec++; if (out_a !== 32'd0 || out_b !== 32'd0) begin nerr++; $display("[TB] FAIL r0_same_cycle got %h/%h exp 0/0", out_a, out_b); end
  endtask

  task automatic test_reset_full();
    do_reset();
    set_wb(5'd3, 32'h33); tick();
    wb_en = 1'b0;
    set_op(3'd4, 5'd3, 5'd0, 5'd7);
    tick();
    set_op(3'd0, 5'd7, 5'd0, 5'd0);
    tick();
    set_op(3'd1, 5'd3, 5'd3, 5'd8);
    tick();
    nvec++; if (out_valid !== 1'b1 || stall_cnt !== 16'd1) begin nerr++; $display("[TB] FAIL prereset got v=%b stall=%0d exp v=1 stall=1", out_valid, stall_cnt); end
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin nerr++; $display("[TB] FAIL rstfull got v=%b stall=%0d exp v=0 stall=0", out_valid, stall_cnt); end
    out_ready = 1'b1;
    set_op(3'd0, 5'd7, 5'd3, 5'd8);
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL rstfull_pending got in_ready %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    nvec++; if (out_b !== 32'd0) begin nerr++; $display("[TB] FAIL rstfull_rf3 got %h exp 0", out_b); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(63) == 0);
      in_valid  = $urandom_range(1);
      in_sel    = 3'($urandom_range(4));
      in_rs     = 5'($urandom_range(7));
      in_rt     = 5'($urandom_range(7));
      in_rd     = 5'($urandom_range(7));
      out_ready = ($urandom_range(3) != 0);
      wb_en     = $urandom_range(1);
      wb_addr   = 5'($urandom_range(7));
      wb_data   = $urandom;
      #1;
      nvec++; if (in_ready !== m_ready()) begin nerr++; $display("[TB] FAIL rand_in_ready cycle %0d got %b exp %b", i, in_ready, m_ready()); end
      tick();
      nvec++; if (out_valid !== m_valid || out_a !== m_a || out_b !== m_b || out_sel !== m_sel || out_rd !== m_rd) begin
        nerr++; $display("[TB] FAIL rand_out cycle %0d got v=%b a=%h b=%h sel=%0d rd=%0d exp v=%b a=%h b=%h sel=%0d rd=%0d",
                         i, out_valid, out_a, out_b, out_sel, out_rd, m_valid, m_a, m_b, m_sel, m_rd);
      end
      nvec++; if (stall_cnt !== 16'(m_stall)) begin nerr++; $display("[TB] FAIL rand_stall cycle %0d got %0d exp %0d", i, stall_cnt, m_stall); end
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_issue();
    test_stall();
    test_wb_forward();
    test_back_to_back();
    test_r0();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
